keystream_packer: RTL and testbench

//  Consumes the serial keystream produced by the 128-bit LFSR PRNG stage and

---
 rtl/keystream_packer.sv | 99 +++++++++
 tb/tb_keystream_packer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keystream_packer.sv
// Packs the serial PRNG keystream MSB-first into WORD_W-bit words and
// buffers them in a small FIFO drained through a valid/ready handshake.
module keystream_packer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic                             i_ks_bit,
  input  logic                             i_ks_valid,
  output logic [WORD_W-1:0]                o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_level,
  output logic                             o_overflow
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  logic [WORD_W-1:0] next_word;
  logic              word_done;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  always_comb begin
    next_word = {shift_reg[WORD_W-2:0], i_ks_bit};
    word_done = i_ks_valid && (bit_cnt == CNT_W'(WORD_W - 1));
    full      = (level == LVL_W'(FIFO_DEPTH));
    pop       = (level != '0) && i_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    push_ok   = word_done && (!full || pop);
    drop      = word_done && full && !pop;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (i_ks_valid) begin
        if (word_done) begin
          bit_cnt   <= '0;
          shift_reg <= '0;
        end else begin
          bit_cnt   <= bit_cnt + CNT_W'(1);
          shift_reg <= next_word;
        end
      end
      if (push_ok) begin
        mem[wr_ptr] <= next_word;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign o_data     = mem[rd_ptr];
  assign o_valid    = (level != '0);
  assign o_level    = level;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_keystream_packer.sv
// Scoreboard bench for keystream_packer: a queue-based reference model predicts
// accepted words; a negedge monitor checks every word the DUT hands over.
module tb_keystream_packer;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         ks_bit = 1'b0;
  logic         ks_valid = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] data;
  logic         valid;
  logic [2:0]   level;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mdl_fifo[$];
  bit           mdl_bits[$];
  bit           mdl_ovf = 1'b0;

  always #5 clk = ~clk;

  keystream_packer #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_flush    (flush),
    .i_ks_bit   (ks_bit),
    .i_ks_valid (ks_valid),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_level    (level),
    .o_overflow (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every handshake the DUT completes must deliver the oldest expected word.
  always @(negedge clk) begin
    if (!rst && !flush && valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=%0h required=none t=%0t", data, $time);
      end else begin
        check("sb_word", data, exp_q.pop_front());
      end
    end
  end

  // One clock: drive inputs, let the edge happen, advance the model, check status.
  task automatic step(input logic v, input logic b, input logic r, input logic f, input logic rs);
    bit           do_pop;
    bit           done;
    logic [W-1:0] w;
    ks_valid = v;
    ks_bit   = b;
    ready    = r;
    flush    = f;
    rst      = rs;
    do_pop   = (mdl_fifo.size() > 0) && r;
    @(posedge clk);
    #1;
    w    = '0;
    done = 1'b0;
    if (rs || f) begin
      mdl_bits.delete();
      mdl_fifo.delete();
      exp_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      if (v) begin
        mdl_bits.push_back(b);
        if (mdl_bits.size() == W) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) w = (w << 1) | W'(mdl_bits[i]);
          mdl_bits.delete();
        end
      end
      if (do_pop) void'(mdl_fifo.pop_front());
      if (done) begin
        if (mdl_fifo.size() == D) mdl_ovf = 1'b1;
        else begin
          mdl_fifo.push_back(w);
          exp_q.push_back(w);
        end
      end
    end
    check("level", level, mdl_fifo.size());
    check("valid", valid, mdl_fifo.size() != 0);
    check("overflow", ovf, mdl_ovf);
    if (mdl_fifo.size() != 0) check("head", data, mdl_fifo[0]);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, r, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r, input logic r_last, input int idle_max);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, w[i], (i == 0) ? r_last : r, 1'b0, 1'b0);
      if (i != 0 && idle_max > 0) idle($urandom_range(1, idle_max), r);
    end
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // back-to-back strobes, consumer always ready
    send_word(8'hB2, 1'b1, 1'b1, 0);
    check("t1_valid", valid, 1);
    check("t1_data", data, 8'hB2);
    idle(1, 1'b1);
    check("t1_valid_after", valid, 0);
    idle(2, 1'b1);

    // sparse strobes
    send_word(8'hB2, 1'b1, 1'b1, 5);
    check("t2_data", data, 8'hB2);
    idle(3, 1'b1);

    // overflow: five words into a four-deep FIFO with no consumer
    for (int k = 1; k <= 5; k++) send_word(W'(k), 1'b0, 1'b0, 0);
    check("t3_level", level, 4);
    check("t3_ovf", ovf, 1);
    check("t3_head", data, 8'h01);
    idle(8, 1'b1);
    check("t3_drained", valid, 0);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_ovf_sticky", ovf, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_ovf", ovf, 0);

    // full FIFO with simultaneous pop on the completing edge
    for (int k = 0; k < 4; k++) send_word(W'(8'h11 + k), 1'b0, 1'b0, 0);
    send_word(8'h25, 1'b0, 1'b1, 0);
    check("t4_level", level, 4);
    check("t4_ovf", ovf, 0);
    idle(8, 1'b1);
    check("t4_sb_empty", exp_q.size(), 0);

    // flush mid-word, flush edge also carries a strobe that must be discarded
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_level", level, 0);
    check("t5_ovf", ovf, 0);
    send_word(8'h5A, 1'b1, 1'b1, 0);
    check("t5_data", data, 8'h5A);
    idle(3, 1'b1);

    // reset mid-word with two words buffered
    send_word(8'hA1, 1'b0, 1'b0, 0);
    send_word(8'hA2, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6_data", data, 0);
    check("t6_level", level, 0);
    check("t6_valid", valid, 0);
    check("t6_ovf", ovf, 0);
    send_word(8'hC3, 1'b1, 1'b1, 0);
    check("t6_fresh", data, 8'hC3);
    idle(3, 1'b1);

    // randomized traffic with varying consumer throughput and rare flushes
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 300; i++) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) < ph), 1'($urandom_range(0, 99) == 0), 1'b0);
      end
    end
    idle(12, 1'b1);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
